// File: rtl/reaction_pkg.sv
// Shared types and defaults for the reaction-timer game sequencer.
package reaction_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LIGHTS = 3'd1,
        ST_HOLD   = 3'd2,
        ST_GO     = 3'd3,
        ST_DONE   = 3'd4,
        ST_FAULT  = 3'd5
    } state_t;

    localparam int DEF_N_LEDS        = 10;
    localparam int DEF_LED_PERIOD_MS = 500;
    localparam int DEF_DELAY_MIN_MS  = 250;
    localparam int DEF_TIMEOUT_MS    = 9999;
    localparam int DEF_TIME_W        = 14;
    localparam int LFSR_W            = 10;

endpackage

// File: rtl/reaction_game_ctrl_tick_counter.sv
// Loadable up/down counter that advances only on the 1 ms tick.
// tc flags the tick on which the count steps onto tc_val.
module tick_counter #(
    parameter int W = 14
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tick,
    input  logic         en,
    input  logic         up,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic [W-1:0] tc_val,
    output logic [W-1:0] count,
    output logic         tc
);

    logic [W-1:0] nxt;

    assign nxt = up ? count + W'(1) : count - W'(1);
    assign tc  = en && tick && (nxt == tc_val);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (en && tick)
            count <= nxt;
    end

endmodule

// File: rtl/reaction_game_ctrl.sv
// Reaction-timer game sequencer: start lights, random hold, then times the
// player's response in ms, flagging false starts and timeouts.
module reaction_game_ctrl
    import reaction_pkg::*;
#(
    parameter int N_LEDS        = DEF_N_LEDS,
    parameter int LED_PERIOD_MS = DEF_LED_PERIOD_MS,
    parameter int DELAY_MIN_MS  = DEF_DELAY_MIN_MS,
    parameter int TIMEOUT_MS    = DEF_TIMEOUT_MS,
    parameter int TIME_W        = DEF_TIME_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              trigger,
    input  logic              response,
    input  logic [LFSR_W-1:0] lfsr_val,
    output logic              lfsr_en,
    output logic [N_LEDS-1:0] ledr,
    output logic [TIME_W-1:0] reaction_ms,
    output logic              result_valid,
    output logic              false_start,
    output logic              busy
);

    localparam int IDX_W = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;

    state_t             state;
    logic [IDX_W-1:0]   led_idx;
    logic               last_led;
    logic               restart;

    logic               a_en, a_up, a_load, a_tc;
    logic [TIME_W-1:0]  a_load_val, a_tc_val, delay_sum;
    logic [TIME_W-1:0]  unused_period_count;

    logic               b_en, b_load, b_tc;
    logic [TIME_W-1:0]  b_count;

    assign last_led  = (led_idx == IDX_W'(N_LEDS - 1));
    assign restart   = trigger &&
                       (state == ST_IDLE || state == ST_DONE || state == ST_FAULT);
    assign delay_sum = TIME_W'(DELAY_MIN_MS) + TIME_W'(lfsr_val);

    // One counter serves both phases: counts up per LED in LIGHTS, down the delay in HOLD.
    assign a_en       = (state == ST_LIGHTS || state == ST_HOLD) && !response;
    assign a_up       = (state == ST_LIGHTS);
    assign a_tc_val   = a_up ? TIME_W'(LED_PERIOD_MS) : '0;
    assign a_load     = restart || (state == ST_LIGHTS && a_tc);
    assign a_load_val = (state == ST_LIGHTS && last_led) ? delay_sum : '0;

    assign b_en   = (state == ST_GO) && !response;
    assign b_load = (state == ST_HOLD) && a_tc;

    tick_counter #(.W(TIME_W)) u_period_cnt (
        .clk(clk), .rst(rst), .tick(tick), .en(a_en), .up(a_up),
        .load(a_load), .load_val(a_load_val), .tc_val(a_tc_val),
        .count(unused_period_count), .tc(a_tc)
    );

    tick_counter #(.W(TIME_W)) u_react_cnt (
        .clk(clk), .rst(rst), .tick(tick), .en(b_en), .up(1'b1),
        .load(b_load), .load_val('0), .tc_val(TIME_W'(TIMEOUT_MS)),
        .count(b_count), .tc(b_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            led_idx      <= '0;
            ledr         <= '0;
            lfsr_en      <= 1'b1;
            reaction_ms  <= '0;
            result_valid <= 1'b0;
            false_start  <= 1'b0;
            busy         <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE, ST_FAULT: begin
                    if (trigger) begin
                        state       <= ST_LIGHTS;
                        led_idx     <= '0;
                        ledr        <= '0;
                        lfsr_en     <= 1'b1;
                        false_start <= 1'b0;
                        busy        <= 1'b1;
                    end
                end
                ST_LIGHTS, ST_HOLD: begin
                    if (response) begin
                        state       <= ST_FAULT;
                        false_start <= 1'b1;
                        ledr        <= '1;
                        lfsr_en     <= 1'b1;
                        busy        <= 1'b0;
                    end else if (a_tc && state == ST_LIGHTS) begin
                        ledr[led_idx] <= 1'b1;
                        led_idx       <= led_idx + IDX_W'(1);
                        if (last_led) begin
                            state   <= ST_HOLD;
                            lfsr_en <= 1'b0;
                        end
                    end else if (a_tc) begin
                        state <= ST_GO;
                        ledr  <= '0;
                    end
                end
                ST_GO: begin
                    if (response || b_tc) begin
                        state        <= ST_DONE;
                        reaction_ms  <= response ? b_count : TIME_W'(TIMEOUT_MS);
                        result_valid <= 1'b1;
                        lfsr_en      <= 1'b1;
                        busy         <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
